multi_sprite_engine: RTL and testbench
======================================

MULTI_SPRITE_ENGINE -- requirements
Module: multi_sprite_engine

Interface
REQ-001 SHALL have parameter NUM_SPRITES, default 4, number of independent sprites (1..8).
REQ-002 SHALL have parameter SPRITE_WIDTH, default 12, sprite columns (1..16).
REQ-003 SHALL have parameter SPRITE_HEIGHT, default 12, sprite rows (1..16).
REQ-004 SHALL have parameter SCALE_LOG2, default 3, where one sprite pixel = 2^SCALE_LOG2 square screen pixels.
REQ-005 SHALL have parameter WIDTH_SMALL, default 100, playfield width in sprite pixels.
REQ-006 SHALL have parameter HEIGHT_SMALL, default 75, playfield height in sprite pixels.
REQ-007 SHALL have parameter COLOR_W, default 6, colour width (rrggbb).
REQ-008 clk  input  1  single clock; all logic on rising edge.
REQ-009 reset  input  1  synchronous, active-high reset.
REQ-010 next_frame  input  1  one-cycle pulse at frame end.
REQ-011 pixel_x  input  11  full-resolution horizontal counter.
REQ-012 pixel_y  input  10  full-resolution vertical counter.
REQ-013 active  input  1  high inside the visible area.
REQ-014 bg_color  input  COLOR_W  background colour for the current pixel.
REQ-015 cfg_we  input  1  config write strobe.
REQ-016 cfg_sel  input  3  target sprite index.
REQ-017 cfg_addr  input  5  register address within the sprite.
REQ-018 cfg_wdata  input  16  write data.
REQ-019 rgb_out  output  COLOR_W  composited colour, registered.
REQ-020 collision  output  1  previous frame contained an overlap of opaque pixels, registered.

Function
REQ-021 Per-sprite map SHALL be: addr 0..SPRITE_HEIGHT-1 = bitmap row (low SPRITE_WIDTH bits, bit SPRITE_WIDTH-1 = leftmost column); 16 = x[7:0]; 17 = y[7:0]; 18 = colour[COLOR_W-1:0]; 19 = ctrl {bit0 enable, bit1 move_en, bit2 dir_x (1 = decreasing), bit3 dir_y (1 = decreasing)}.
REQ-022 Writes with cfg_sel >= NUM_SPRITES or an unmapped cfg_addr SHALL be ignored with no side effects.
REQ-023 Writes to x SHALL clamp to XMAX = WIDTH_SMALL-SPRITE_WIDTH; writes to y SHALL clamp to YMAX = HEIGHT_SMALL-SPRITE_HEIGHT.
REQ-024 Scaled coordinates SHALL be sx = pixel_x >> SCALE_LOG2 and sy = pixel_y >> SCALE_LOG2, with comparisons at 9 bits so that x+SPRITE_WIDTH cannot overflow.
REQ-025 Sprite i SHALL be opaque when enable=1, x<=sx<x+SPRITE_WIDTH, y<=sy<y+SPRITE_HEIGHT, and bitmap[sy-y][SPRITE_WIDTH-1-(sx-x)] = 1.
REQ-026 Output colour SHALL be the colour of the lowest-index opaque sprite; otherwise bg_color; and 0 whenever active = 0.
REQ-027 rgb_out SHALL be registered with exactly 1-cycle latency from pixel_x/pixel_y/active/bg_color.
REQ-028 An internal hit flag SHALL set in any active cycle where two or more sprites are opaque.
REQ-029 At next_frame, collision SHALL be loaded with the hit flag (including a hit in that same cycle), and hit SHALL clear.
REQ-030 At next_frame, each sprite with enable & move_en SHALL step x and y by ±1 per its dir bits.
REQ-031 Bounce rule: a sprite stepping beyond 0 or beyond XMAX/YMAX SHALL instead reverse that dir bit and step one inward in the same frame.
REQ-032 A cfg write and a movement update to the same sprite field in the same cycle SHALL resolve with the write winning.
REQ-033 Bitmap writes SHALL take effect on the next cycle, with no frame-synchronisation or buffering.

Reset
REQ-034 reset=1 SHALL clear every bitmap, x, y, colour and ctrl field, hit, collision and rgb_out to 0.
REQ-035 Reset SHALL take priority over next_frame and cfg_we in the same cycle.
REQ-036 Reset asserted mid-frame SHALL drive rgb_out to 0 on the following cycle.

Verification
REQ-037 Write sprite0 row0 = 0x800, x=10, y=5, colour=0x30, ctrl=1; drive pixel (80,40), active=1 -> rgb_out=0x30 one cycle later; pixel (79,40) -> bg_color.
REQ-038 Sprites 0 and 1 both opaque at the same pixel (colours 0x30, 0x0C) -> rgb_out=0x30; after next_frame -> collision=1; next frame with no overlap, after next_frame -> collision=0.
REQ-039 x=88 (XMAX), ctrl=0x3 (move, increasing), next_frame -> x=87 and dir_x=1; x=0 with dir_x=1 -> x=1 and dir_x=0.
REQ-040 Write x=200 -> readback via render shows x=88; cfg_sel=5 with NUM_SPRITES=4 -> no state change.
REQ-041 cfg write x=20 in the same cycle as next_frame on a moving sprite -> x=20.
REQ-042 active=0 with a sprite opaque -> rgb_out=0; reset pulse mid-line -> rgb_out=0 and all sprites disabled.

Source files
------------

// File: rtl/multi_sprite_engine.sv
// multi_sprite_engine
// Composites up to NUM_SPRITES monochrome bitmap sprites over a background
// colour on a scaled-down playfield, moves enabled sprites one step per frame
// with edge bounce, and flags frames in which opaque sprite pixels overlapped.
//
// Ports
//   clk         system clock, all logic on the rising edge
//   reset       synchronous active-high reset
//   next_frame  one-cycle pulse at frame end (movement + collision latch)
//   pixel_x/y   full-resolution raster position
//   active      high inside the visible area
//   bg_color    background colour for the current pixel
//   cfg_*       register write port: sprite select, address, data
//   rgb_out     composited colour, one cycle after the pixel inputs
//   collision   previous frame contained an overlap of opaque pixels
//
// Per-sprite register map
//   0..SPRITE_HEIGHT-1  bitmap rows (bit SPRITE_WIDTH-1 = leftmost column)
//   16 x, 17 y (both clamped), 18 colour
//   19 ctrl {dir_y, dir_x, move_en, enable} (dir = 1 means decreasing)

module multi_sprite_engine #(
   parameter int NUM_SPRITES   = 4,
   parameter int SPRITE_WIDTH  = 12,
   parameter int SPRITE_HEIGHT = 12,
   parameter int SCALE_LOG2    = 3,
   parameter int WIDTH_SMALL   = 100,
   parameter int HEIGHT_SMALL  = 75,
   parameter int COLOR_W       = 6
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               next_frame,
   input  logic [10:0]        pixel_x,
   input  logic [9:0]         pixel_y,
   input  logic               active,
   input  logic [COLOR_W-1:0] bg_color,
   input  logic               cfg_we,
   input  logic [2:0]         cfg_sel,
   input  logic [4:0]         cfg_addr,
   input  logic [15:0]        cfg_wdata,
   output logic [COLOR_W-1:0] rgb_out,
   output logic               collision
);

   localparam logic [7:0] XMAX = 8'(WIDTH_SMALL - SPRITE_WIDTH);
   localparam logic [7:0] YMAX = 8'(HEIGHT_SMALL - SPRITE_HEIGHT);
   localparam logic [8:0] SW9  = 9'(SPRITE_WIDTH);
   localparam logic [8:0] SH9  = 9'(SPRITE_HEIGHT);
   localparam logic [3:0] NS4  = 4'(NUM_SPRITES);

   logic [SPRITE_WIDTH-1:0] bitmap [NUM_SPRITES][SPRITE_HEIGHT];
   logic [7:0]              pos_x  [NUM_SPRITES];
   logic [7:0]              pos_y  [NUM_SPRITES];
   logic [COLOR_W-1:0]      color  [NUM_SPRITES];
   logic [3:0]              ctrl   [NUM_SPRITES];

   logic [7:0]              pos_x_nxt [NUM_SPRITES];
   logic [7:0]              pos_y_nxt [NUM_SPRITES];
   logic [3:0]              ctrl_nxt  [NUM_SPRITES];

   logic                    hit;
   logic                    sel_ok;
   logic [7:0]              wr_x;
   logic [7:0]              wr_y;

   logic [10:0]             sx_full;
   logic [9:0]              sy_full;
   logic [8:0]              sx;
   logic [8:0]              sy;
   logic                    s_oob;
   logic [NUM_SPRITES-1:0]  opaque;
   logic [COLOR_W-1:0]      pix_color;
   logic                    multi;

   // One movement step on one axis; returns {dir, pos}. Stepping past either
   // edge reverses the direction and moves one step inward instead.
   function automatic logic [8:0] step(input logic [7:0] p, input logic d,
                                       input logic [7:0] mx);
      logic [8:0] r;
      r = {d, p};
      if (mx != 8'd0) begin
         if (!d) begin
            if (p >= mx) r = {1'b1, p - 8'd1};
            else         r = {1'b0, p + 8'd1};
         end else begin
            if (p == 8'd0) r = {1'b0, 8'd1};
            else           r = {1'b1, p - 8'd1};
         end
      end
      return r;
   endfunction

   assign sel_ok = ({1'b0, cfg_sel} < NS4);
   assign wr_x   = (cfg_wdata[7:0] > XMAX) ? XMAX : cfg_wdata[7:0];
   assign wr_y   = (cfg_wdata[7:0] > YMAX) ? YMAX : cfg_wdata[7:0];

   // Next-state for position/ctrl: movement first, then a same-cycle
   // register write to the same field overrides it.
   always_comb begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
         pos_x_nxt[i] = pos_x[i];
         pos_y_nxt[i] = pos_y[i];
         ctrl_nxt[i]  = ctrl[i];
         if (next_frame && ctrl[i][0] && ctrl[i][1]) begin
            {ctrl_nxt[i][2], pos_x_nxt[i]} = step(pos_x[i], ctrl[i][2], XMAX);
            {ctrl_nxt[i][3], pos_y_nxt[i]} = step(pos_y[i], ctrl[i][3], YMAX);
         end
         if (cfg_we && sel_ok && (cfg_sel == 3'(i))) begin
            case (cfg_addr)
               5'd16:   pos_x_nxt[i] = wr_x;
               5'd17:   pos_y_nxt[i] = wr_y;
               5'd19:   ctrl_nxt[i]  = cfg_wdata[3:0];
               default: ;
            endcase
         end
      end
   end

   assign sx_full = pixel_x >> SCALE_LOG2;
   assign sy_full = pixel_y >> SCALE_LOG2;
   assign sx      = sx_full[8:0];
   assign sy      = sy_full[8:0];
   // Raster positions beyond 9 bits can never land on a sprite.
   assign s_oob   = (sx_full[10:9] != 2'b00) || sy_full[9];

   always_comb begin
      logic [8:0]              dx;
      logic [8:0]              dy;
      logic [SPRITE_WIDTH-1:0] row_bits;
      logic                    pix_bit;
      logic                    in_x;
      logic                    in_y;
      logic                    seen;
      dx        = '0;
      dy        = '0;
      row_bits  = '0;
      pix_bit   = 1'b0;
      in_x      = 1'b0;
      in_y      = 1'b0;
      seen      = 1'b0;
      multi     = 1'b0;
      opaque    = '0;
      pix_color = bg_color;
      for (int i = 0; i < NUM_SPRITES; i++) begin
         dx   = sx - {1'b0, pos_x[i]};
         dy   = sy - {1'b0, pos_y[i]};
         in_x = (sx >= {1'b0, pos_x[i]}) && (sx < ({1'b0, pos_x[i]} + SW9));
         in_y = (sy >= {1'b0, pos_y[i]}) && (sy < ({1'b0, pos_y[i]} + SH9));
         row_bits = '0;
         for (int r = 0; r < SPRITE_HEIGHT; r++)
            if (dy == 9'(r)) row_bits = bitmap[i][r];
         pix_bit = 1'b0;
         for (int c = 0; c < SPRITE_WIDTH; c++)
            if (dx == 9'(c)) pix_bit = row_bits[SPRITE_WIDTH-1-c];
         opaque[i] = ctrl[i][0] && !s_oob && in_x && in_y && pix_bit;
         multi     = multi | (seen & opaque[i]);
         seen      = seen | opaque[i];
      end
      // Walk from the top index down so the lowest opaque index wins.
      for (int i = NUM_SPRITES - 1; i >= 0; i--)
         if (opaque[i]) pix_color = color[i];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            for (int r = 0; r < SPRITE_HEIGHT; r++)
               bitmap[i][r] <= '0;
            pos_x[i] <= '0;
            pos_y[i] <= '0;
            color[i] <= '0;
            ctrl[i]  <= '0;
         end
         hit       <= 1'b0;
         collision <= 1'b0;
         rgb_out   <= '0;
      end else begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            pos_x[i] <= pos_x_nxt[i];
            pos_y[i] <= pos_y_nxt[i];
            ctrl[i]  <= ctrl_nxt[i];
            if (cfg_we && sel_ok && (cfg_sel == 3'(i))) begin
               for (int r = 0; r < SPRITE_HEIGHT; r++)
                  if (cfg_addr == 5'(r)) bitmap[i][r] <= cfg_wdata[SPRITE_WIDTH-1:0];
               if (cfg_addr == 5'd18) color[i] <= cfg_wdata[COLOR_W-1:0];
            end
         end
         rgb_out <= active ? pix_color : '0;
         // An overlap in the frame-end cycle itself still counts for the
         // frame being closed.
         if (next_frame) begin
            collision <= hit | (active & multi);
            hit       <= 1'b0;
         end else if (active && multi) begin
            hit <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_multi_sprite_engine.sv
// tb_multi_sprite_engine
// Directed bench for multi_sprite_engine with default parameters. Each driven
// pixel pushes its expected colour onto a scoreboard queue; the value is
// popped and compared when rgb_out is produced one cycle later.

module tb_multi_sprite_engine;

   logic        clk = 1'b0;
   logic        reset;
   logic        next_frame;
   logic [10:0] pixel_x;
   logic [9:0]  pixel_y;
   logic        active;
   logic [5:0]  bg_color;
   logic        cfg_we;
   logic [2:0]  cfg_sel;
   logic [4:0]  cfg_addr;
   logic [15:0] cfg_wdata;
   logic [5:0]  rgb_out;
   logic        collision;

   logic [5:0]  exp_q [$];
   string       tag_q [$];
   int          vectors = 0;
   int          miscompares = 0;

   always #5 clk = ~clk;

   multi_sprite_engine dut (
      .clk        (clk),
      .reset      (reset),
      .next_frame (next_frame),
      .pixel_x    (pixel_x),
      .pixel_y    (pixel_y),
      .active     (active),
      .bg_color   (bg_color),
      .cfg_we     (cfg_we),
      .cfg_sel    (cfg_sel),
      .cfg_addr   (cfg_addr),
      .cfg_wdata  (cfg_wdata),
      .rgb_out    (rgb_out),
      .collision  (collision)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      vectors++;
      assert (obs === expv)
      else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   // Called at a falling edge; returns at a falling edge.
   task automatic wr(input logic [2:0] s, input logic [4:0] a, input logic [15:0] d);
      cfg_we    = 1'b1;
      cfg_sel   = s;
      cfg_addr  = a;
      cfg_wdata = d;
      @(negedge clk);
      cfg_we    = 1'b0;
   endtask

   task automatic frame();
      next_frame = 1'b1;
      @(negedge clk);
      next_frame = 1'b0;
   endtask

   task automatic pix(input logic [10:0] px, input logic [9:0] py, input logic act,
                      input logic [5:0] bg, input logic [5:0] expv, input string tag);
      logic [5:0] e;
      string      t;
      pixel_x  = px;
      pixel_y  = py;
      active   = act;
      bg_color = bg;
      exp_q.push_back(expv);
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         chk("scoreboard_empty", 16'd1, 16'd0);
      end else begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         chk(t, 16'(rgb_out), 16'(e));
      end
      @(negedge clk);
      active = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset      = 1'b1;
      next_frame = 1'b0;
      pixel_x    = '0;
      pixel_y    = '0;
      active     = 1'b0;
      bg_color   = '0;
      cfg_we     = 1'b0;
      cfg_sel    = '0;
      cfg_addr   = '0;
      cfg_wdata  = '0;
      repeat (2) @(negedge clk);

      pix(0, 0, 1, 6'h3F, 6'h00, "reset_rgb");
      chk("reset_collision", 16'(collision), 16'd0);
      reset = 1'b0;

      // Sprite 0: single opaque pixel at (10,5)
      wr(0, 0, 16'h800); wr(0, 16, 16'd10); wr(0, 17, 16'd5);
      wr(0, 18, 16'h30); wr(0, 19, 16'h1);
      pix(80, 40, 1, 6'h15, 6'h30, "s0_hit");
      pix(79, 40, 1, 6'h15, 6'h15, "s0_left_edge");
      pix(87, 47, 1, 6'h15, 6'h30, "s0_scaled_corner");
      pix(88, 40, 1, 6'h15, 6'h15, "s0_col1_clear");
      pix(80, 48, 1, 6'h15, 6'h15, "s0_row1_clear");

      // Sprite 1 overlapping sprite 0, plus an extra row of its own
      wr(1, 0, 16'h800); wr(1, 1, 16'h800); wr(1, 16, 16'd10); wr(1, 17, 16'd5);
      wr(1, 18, 16'h0C); wr(1, 19, 16'h1);
      pix(80, 40, 1, 6'h15, 6'h30, "prio_s0_over_s1");
      pix(80, 48, 1, 6'h15, 6'h0C, "s1_only_row1");
      frame();
      chk("coll_after_overlap", 16'(collision), 16'd1);

      pix(80, 40, 0, 6'h15, 6'h00, "inactive_black");
      frame();
      chk("coll_inactive_overlap", 16'(collision), 16'd0);

      // Overlap in the very cycle of next_frame
      next_frame = 1'b1;
      pix(80, 40, 1, 6'h15, 6'h30, "prio_at_frame_edge");
      next_frame = 1'b0;
      chk("coll_same_cycle", 16'(collision), 16'd1);

      wr(1, 16, 16'd30);
      pix(240, 40, 1, 6'h15, 6'h0C, "s1_moved");
      pix(80, 40, 1, 6'h15, 6'h30, "s0_alone");
      frame();
      chk("coll_cleared", 16'(collision), 16'd0);

      // Clamping and ignored writes
      wr(0, 16, 16'd200);
      pix(704, 40, 1, 6'h15, 6'h30, "x_clamp");
      pix(703, 40, 1, 6'h15, 6'h15, "x_clamp_left");
      wr(0, 17, 16'd200);
      pix(704, 504, 1, 6'h15, 6'h30, "y_clamp");
      pix(704, 503, 1, 6'h15, 6'h15, "y_clamp_above");
      wr(5, 16, 16'd0); wr(5, 19, 16'h0); wr(0, 20, 16'hFFFF); wr(0, 31, 16'hFFFF);
      pix(704, 504, 1, 6'h15, 6'h30, "bad_sel_ignored");
      pix(240, 40, 1, 6'h15, 6'h0C, "bad_sel_s1_intact");

      // Movement and bounce on sprite 2
      wr(0, 19, 16'h0); wr(1, 19, 16'h0);
      wr(2, 0, 16'h800); wr(2, 16, 16'd88); wr(2, 17, 16'd0);
      wr(2, 18, 16'h03); wr(2, 19, 16'h3);
      pix(704, 0, 1, 6'h15, 6'h03, "s2_at_xmax");
      frame();                                   // x 88->87 dir_x=1, y 0->1
      pix(696, 8, 1, 6'h15, 6'h03, "bounce_xmax");
      pix(704, 8, 1, 6'h15, 6'h15, "bounce_xmax_old");
      frame();                                   // x 86, y 2
      pix(688, 16, 1, 6'h15, 6'h03, "dir_x_reversed");
      wr(2, 16, 16'd0); wr(2, 19, 16'h7);
      frame();                                   // x 0->1 dir_x=0, y 3
      pix(8, 24, 1, 6'h15, 6'h03, "bounce_zero");
      pix(0, 24, 1, 6'h15, 6'h15, "bounce_zero_old");
      frame();                                   // x 2, y 4
      pix(16, 32, 1, 6'h15, 6'h03, "dir_x_restored");

      // Register write and movement in the same cycle
      wr(2, 19, 16'h3); wr(2, 17, 16'd10);
      cfg_we     = 1'b1;
      cfg_sel    = 3'd2;
      cfg_addr   = 5'd16;
      cfg_wdata  = 16'd20;
      next_frame = 1'b1;
      @(negedge clk);
      cfg_we     = 1'b0;
      next_frame = 1'b0;                         // x 20 (write), y 11 (moved)
      pix(160, 88, 1, 6'h15, 6'h03, "write_wins");
      pix(160, 80, 1, 6'h15, 6'h15, "write_wins_y_moved");

      // Reset in the middle of a line
      reset = 1'b1;
      pix(160, 88, 1, 6'h15, 6'h00, "reset_mid_line");
      reset = 1'b0;
      pix(160, 88, 1, 6'h15, 6'h15, "post_reset_s2_gone");
      pix(240, 40, 1, 6'h15, 6'h15, "post_reset_s1_gone");
      chk("post_reset_collision", 16'(collision), 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
